// File: rtl/qsys_gpo_ser_pkg.sv
// Shared types and defaults for the GPO shift-register serializer.
package qsys_gpo_ser_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  localparam int DEF_WIDTH          = 32;
  localparam int DEF_CLK_DIV        = 4;
  localparam int DEF_REFRESH_CYCLES = 1000000;

  // A frame is always sent after reset, even if the input word is zero.
  localparam logic INIT_PEND_RST = 1'b1;

endpackage

// File: rtl/qsys_gpo_ser_div.sv
// Phase divider: counts 0..CLK_DIV-1 while enabled and strobes on the last count.
module qsys_gpo_ser_div
  import qsys_gpo_ser_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic phase_end
);

  localparam logic [15:0] TC = 16'(CLK_DIV - 1);

  logic [15:0] divcnt;

  assign phase_end = en && (divcnt == TC);

  // Wrapping on phase_end keeps every new phase starting from zero.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      divcnt <= '0;
    end else if (en) begin
      divcnt <= phase_end ? '0 : divcnt + 16'd1;
    end
  end

endmodule

// File: rtl/qsys_gpo_serializer.sv
// Serializes the GPO word onto a 74HC595-style chain after reset and on every change.
// Optional periodic resend is enabled by defining QSYS_GPO_SER_REFRESH_EN.
//
// state    | meaning
// IDLE     | waiting for init, change or refresh; chain outputs held
// SHIFT_LO | shift clock low, data bit presented
// SHIFT_HI | shift clock high, chain samples data
// LATCH    | storage-register latch pulse
module qsys_gpo_serializer
  import qsys_gpo_ser_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int CLK_DIV        = DEF_CLK_DIV,
  parameter int MSB_FIRST      = 1,
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
  input  logic             csi_MCLK_clk,
  input  logic             rsi_MRST_reset,
  input  logic [WIDTH-1:0] coe_GPO_in,
  output logic             coe_SR_dat,
  output logic             coe_SR_clk,
  output logic             coe_SR_latch,
  output logic             coe_SR_oe_n,
  output logic             coe_busy
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] last_sent;
  logic [BW-1:0]    bitcnt;
  logic [BW-1:0]    bitcnt_inc;
  logic             init_pend;
  logic             phase_end;
  logic             start;
  logic             refresh_due;
  logic             bit_first;
  logic             bit_next;

  qsys_gpo_ser_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk       (csi_MCLK_clk),
    .reset     (rsi_MRST_reset),
    .en        (state != IDLE),
    .clr       (state == IDLE),
    .phase_end (phase_end)
  );

`ifdef QSYS_GPO_SER_REFRESH_EN
  logic [31:0] idle_cnt;

  assign refresh_due = (idle_cnt == 32'(REFRESH_CYCLES - 1));

  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset || start) begin
      idle_cnt <= '0;
    end else if (state == IDLE) begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  assign refresh_due = 1'b0;
`endif

  assign start      = (state == IDLE) && (init_pend || (coe_GPO_in != last_sent) || refresh_due);
  assign bitcnt_inc = bitcnt + BW'(1);
  assign bit_first  = (MSB_FIRST != 0) ? coe_GPO_in[WIDTH-1] : coe_GPO_in[0];
  assign bit_next   = (MSB_FIRST != 0) ? shadow[LAST_BIT - bitcnt_inc] : shadow[bitcnt_inc];

  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      state        <= IDLE;
      shadow       <= '0;
      last_sent    <= '0;
      bitcnt       <= '0;
      init_pend    <= INIT_PEND_RST;
      coe_SR_dat   <= 1'b0;
      coe_SR_clk   <= 1'b0;
      coe_SR_latch <= 1'b0;
      coe_SR_oe_n  <= 1'b1;
      coe_busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shadow     <= coe_GPO_in;
            last_sent  <= coe_GPO_in;
            bitcnt     <= '0;
            init_pend  <= 1'b0;
            coe_SR_dat <= bit_first;
            coe_busy   <= 1'b1;
            state      <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (phase_end) begin
            coe_SR_clk <= 1'b1;
            state      <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (phase_end) begin
            coe_SR_clk <= 1'b0;
            if (bitcnt == LAST_BIT) begin
              coe_SR_latch <= 1'b1;
              state        <= LATCH;
            end else begin
              bitcnt     <= bitcnt_inc;
              coe_SR_dat <= bit_next;
              state      <= SHIFT_LO;
            end
          end
        end
        LATCH: begin
          // Chain outputs are enabled only once valid data has been latched.
          if (phase_end) begin
            coe_SR_latch <= 1'b0;
            coe_busy     <= 1'b0;
            coe_SR_oe_n  <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qsys_gpo_serializer.sv
// Scoreboard bench: default instance (MSB first, CLK_DIV=4) and an LSB-first CLK_DIV=1 instance.
module tb_qsys_gpo_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gpo_a;
  logic [31:0] gpo_b;
  logic        a_dat, a_sclk, a_latch, a_oe_n, a_busy;
  logic        b_dat, b_sclk, b_latch, b_oe_n, b_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 clk = ~clk;

  qsys_gpo_serializer dut_a (
    .csi_MCLK_clk   (clk),
    .rsi_MRST_reset (rst),
    .coe_GPO_in     (gpo_a),
    .coe_SR_dat     (a_dat),
    .coe_SR_clk     (a_sclk),
    .coe_SR_latch   (a_latch),
    .coe_SR_oe_n    (a_oe_n),
    .coe_busy       (a_busy)
  );

  qsys_gpo_serializer #(
    .WIDTH     (32),
    .CLK_DIV   (1),
    .MSB_FIRST (0)
  ) dut_b (
    .csi_MCLK_clk   (clk),
    .rsi_MRST_reset (rst),
    .coe_GPO_in     (gpo_b),
    .coe_SR_dat     (b_dat),
    .coe_SR_clk     (b_sclk),
    .coe_SR_latch   (b_latch),
    .coe_SR_oe_n    (b_oe_n),
    .coe_busy       (b_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor A: MSB-first collection, frame closes on the latch falling edge.
  logic [31:0] a_bits;
  int a_nbits, a_busy_n, a_latch_n, a_frames;
  logic a_prev_sclk, a_prev_latch;
  initial begin
    a_bits = '0; a_nbits = 0; a_busy_n = 0; a_latch_n = 0; a_frames = 0;
    a_prev_sclk = 1'b0; a_prev_latch = 1'b0;
  end

  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (rst) begin
      a_bits = '0; a_nbits = 0; a_busy_n = 0; a_latch_n = 0;
      a_prev_sclk = 1'b0; a_prev_latch = 1'b0;
    end else begin
      if (a_sclk && !a_prev_sclk) begin
        a_bits = {a_bits[30:0], a_dat};
        a_nbits++;
      end
      if (a_busy) a_busy_n++;
      if (a_latch) a_latch_n++;
      if (!a_latch && a_prev_latch) begin
        a_frames++;
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_frame actual=%h required=none", a_bits);
        end else begin
          exp_w = qa.pop_front();
          chk("a_frame_word", a_bits, exp_w);
          chk("a_bit_count", 32'(a_nbits), 32'd32);
          chk("a_latch_len", 32'(a_latch_n), 32'd4);
          chk("a_busy_len", 32'(a_busy_n), 32'd260);
          chk("a_oe_n_after_latch", {31'd0, a_oe_n}, 32'd0);
          chk("a_busy_after_latch", {31'd0, a_busy}, 32'd0);
        end
        a_bits = '0; a_nbits = 0; a_busy_n = 0; a_latch_n = 0;
      end
      a_prev_sclk = a_sclk;
      a_prev_latch = a_latch;
    end
  end

  // Monitor B: LSB-first collection with CLK_DIV=1.
  logic [31:0] b_bits;
  int b_nbits, b_busy_n, b_latch_n, b_toggles, b_frames;
  logic b_prev_sclk, b_prev_latch;
  initial begin
    b_bits = '0; b_nbits = 0; b_busy_n = 0; b_latch_n = 0; b_toggles = 0; b_frames = 0;
    b_prev_sclk = 1'b0; b_prev_latch = 1'b0;
  end

  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (rst) begin
      b_bits = '0; b_nbits = 0; b_busy_n = 0; b_latch_n = 0; b_toggles = 0;
      b_prev_sclk = 1'b0; b_prev_latch = 1'b0;
    end else begin
      if (b_sclk && !b_prev_sclk) begin
        b_bits = {b_dat, b_bits[31:1]};
        b_nbits++;
      end
      if (b_sclk != b_prev_sclk) b_toggles++;
      if (b_busy) b_busy_n++;
      if (b_latch) b_latch_n++;
      if (!b_latch && b_prev_latch) begin
        b_frames++;
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_frame actual=%h required=none", b_bits);
        end else begin
          exp_w = qb.pop_front();
          chk("b_frame_word", b_bits, exp_w);
          chk("b_bit_count", 32'(b_nbits), 32'd32);
          chk("b_latch_len", 32'(b_latch_n), 32'd1);
          chk("b_busy_len", 32'(b_busy_n), 32'd65);
          chk("b_sclk_toggles", 32'(b_toggles), 32'd64);
        end
        b_bits = '0; b_nbits = 0; b_busy_n = 0; b_latch_n = 0; b_toggles = 0;
      end
      b_prev_sclk = b_sclk;
      b_prev_latch = b_latch;
    end
  end

  task automatic wait_idle_a(input int max_cycles);
    int n;
    n = 0;
    while (a_busy && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (a_busy) begin
      checks++; errors++;
      $display("FAIL a_frame_timeout actual=busy required=idle");
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dat"},   {31'd0, a_dat},   32'd0);
    chk({tag, "_sclk"},  {31'd0, a_sclk},  32'd0);
    chk({tag, "_latch"}, {31'd0, a_latch}, 32'd0);
    chk({tag, "_oe_n"},  {31'd0, a_oe_n},  32'd1);
    chk({tag, "_busy"},  {31'd0, a_busy},  32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    gpo_a = 32'h5A5A_5A5A;
    gpo_b = 32'h8000_0001;
    qa.push_back(32'h5A5A_5A5A);
    qb.push_back(32'h8000_0001);
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Initial frame after reset.
    @(negedge clk);
    chk("init_busy_start", {31'd0, a_busy}, 32'd1);
    chk("init_oe_n_during", {31'd0, a_oe_n}, 32'd1);
    wait_idle_a(2000);
    gpo_b = 32'h0000_00F3;
    qb.push_back(32'h0000_00F3);

    // Single change starts a frame on the next edge, then silence while stable.
    repeat (20) @(negedge clk);
    gpo_a = 32'h0000_0001;
    qa.push_back(32'h0000_0001);
    @(negedge clk);
    chk("change_latency", {31'd0, a_busy}, 32'd1);
    wait_idle_a(2000);
    repeat (10000) @(negedge clk);
    chk("stable_frames", 32'(a_frames), 32'd2);

    // Mid-frame changes are coalesced into one follow-up frame.
    gpo_a = 32'h0000_FFFF;
    qa.push_back(32'h0000_FFFF);
    @(negedge clk);
    chk("coalesce_busy", {31'd0, a_busy}, 32'd1);
    repeat (50) @(negedge clk);
    gpo_a = 32'hFFFF_0000;
    repeat (50) @(negedge clk);
    gpo_a = 32'h1234_5678;
    qa.push_back(32'h1234_5678);
    wait_idle_a(2000);
    @(negedge clk);
    chk("coalesce_restart", {31'd0, a_busy}, 32'd1);
    wait_idle_a(2000);
    repeat (500) @(negedge clk);
    chk("coalesce_frames", 32'(a_frames), 32'd4);

    // Reset while bit 15 is on the wire; the partial frame must never latch.
    gpo_a = 32'hCAFE_BABE;
    @(negedge clk);
    chk("abort_busy", {31'd0, a_busy}, 32'd1);
    repeat (121) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("abort");
    repeat (2) @(negedge clk);
    qa.push_back(32'hCAFE_BABE);
    qb.push_back(32'h0000_00F3);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", {31'd0, a_busy}, 32'd1);
    chk("post_reset_b_busy", {31'd0, b_busy}, 32'd1);
    wait_idle_a(2000);
    repeat (50) @(negedge clk);

    chk("a_total_frames", 32'(a_frames), 32'd5);
    chk("b_total_frames", 32'(b_frames), 32'd3);
    chk("a_queue_left", 32'(qa.size()), 32'd0);
    chk("b_queue_left", 32'(qb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
